gray_mem_arbiter: RTL and testbench
===================================

// Module: gray_mem_arbiter
// PURPOSE
//  Shares the single gray-image read port (128x128, 8-bit pixels) among NUM_REQ pixel-window engines (LBP and peers).
//  Round-robin arbitration; an optional lock keeps the port with one engine for a 3x3 window fetch.
//  Routes each read return to the engine that issued it.
//  Sits between the engines' read ports and the host gray memory interface.
// PARAMETERS
//  NUM_REQ    2   number of requesting engines (2..4)
//  AW         14  pixel address width, {row[6:0],col[6:0]}
//  DW         8   pixel data width
//  MEM_LAT    1   cycles from mem_rd high until mem_rdata is valid (1..4)
//  MAX_BURST  9   maximum consecutive locked grants to one engine before forced rotation
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-high
//  mem_ready  in   1           host memory ready; no read is issued while it is 0
//  mem_rd     out  1           read strobe, one cycle per read
//  mem_addr   out  AW          read address, valid while mem_rd=1
//  mem_rdata  in   DW          read data, valid MEM_LAT cycles after mem_rd
//  req        in   NUM_REQ     per-engine read request, level
//  addr       in   NUM_REQ*AW  per-engine address, engine i at [i*AW +: AW]
//  lock       in   NUM_REQ     per-engine lock: keep the grant after this beat
//  gnt        out  NUM_REQ     one-hot, combinational; accept of req/addr this cycle
//  rvalid     out  NUM_REQ     one-hot, one cycle; rdata belongs to engine i
//  rdata      out  DW          registered return data, shared by all engines
// BEHAVIOUR
//  Reset values: mem_rd=0, mem_addr=0, gnt=0, rvalid=0, rdata=0, rr_ptr=0, state=S_ARB, burst_cnt=0.
//  All in-flight owner tags are cleared on reset.
//  Grant condition: gnt[i]=1 only when mem_ready=1 and req[i]=1.
//   At most one grant per cycle.
//   An engine holds req and addr until it sees gnt.
//  Timing: gnt in cycle T -> mem_rd=1 and mem_addr=addr[i] in T+1 (registered).
//   mem_rdata is sampled in T+1+MEM_LAT.
//   rvalid[i]=1 and rdata are driven in T+2+MEM_LAT; this latency is fixed.
//  Owner tags: a shift register of depth MEM_LAT+1 carries {valid, owner_id} alongside each read.
//   Back-to-back grants keep full throughput of one read per cycle.
//  State S_ARB:
//   Winner is the first i with req[i]=1, scanning from rr_ptr upward and wrapping.
//   If winner lock=0: rr_ptr <= winner+1 (mod NUM_REQ); stay in S_ARB.
//   If winner lock=1: owner <= winner, burst_cnt <= 1; go to S_LOCK.
//  State S_LOCK: only the owner can be granted; other engines wait.
//   Owner granted with lock=1 and burst_cnt < MAX_BURST-1: burst_cnt++; stay.
//   Owner granted with lock=0, or this grant brings burst_cnt to MAX_BURST: this is the last beat.
//    rr_ptr <= owner+1; go to S_ARB.
//   Owner req=0 in S_LOCK: no grant this cycle; rr_ptr <= owner+1; go to S_ARB.
//  mem_ready=0: no grant and no mem_rd. State, rr_ptr and burst_cnt hold.
//   In-flight reads still return on schedule.
//  Simultaneous requests are resolved by rr_ptr alone. The index is taken mod NUM_REQ, so it wraps from NUM_REQ-1 to 0.
//  lock from a non-winning engine is ignored.
//  Reset mid-burst: reads in flight are dropped; no rvalid occurs after reset is released until a new grant.
// STRUCTURE
//  Shared package gray_arb_pkg:
//   AW/DW defaults, state localparams S_ARB=1'b0 and S_LOCK=1'b1.
//   Function for the rr index increment.
//  Sub-module gray_arb_rr_pick: combinational round-robin picker.
//   Inputs req and rr_ptr; outputs one-hot grant, winner index and any_req.
//  Top level holds: FSM, burst counter, mem_rd/mem_addr registers, owner-tag pipeline, rdata/rvalid registers.
// TESTING
//  Setup for all scenarios: MEM_LAT=1; memory model returns data = addr[7:0].
//  1 Single read: mem_ready=1; req0=1, addr0=14'h0081, lock0=0 at cycle T.
//    -> gnt0 at T; mem_rd with mem_addr=0081 at T+1; rvalid0=1 with rdata=8'h81 at T+3; rr_ptr=1.
//  2 Contention: req0=req1=1 held, lock=0, rr_ptr=0.
//    -> grants alternate 0,1,0,1; one mem_rd per cycle; rvalid follows the same order, 3 cycles later.
//  3 Locked window: engine1 requests 9 addrs, lock1=1 on beats 1-8 and 0 on beat 9, with req0=1 throughout.
//    -> gnt1 for 9 consecutive cycles, then gnt0; rvalid1 x9 in address order.
//  4 Forced rotation: lock1 held at 1 for 12 beats; req0=1.
//    -> after 9 grants to engine1, engine0 is granted; engine1 is granted again afterwards.
//  5 mem_ready low: deassert for 4 cycles while req0=1.
//    -> no gnt and no mem_rd during those cycles; grant resumes the cycle mem_ready returns to 1.
//  6 Reset mid-burst: assert reset 1 cycle after a grant.
//    -> all outputs 0; no rvalid after reset is released; next request gets the normal 3-cycle latency.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// rtl/gray_arb_pkg.sv - shared types and helpers for the gray memory arbiter
package gray_arb_pkg;

  localparam int AW_DEF = 14;
  localparam int DW_DEF = 8;

  typedef enum logic {
    S_ARB  = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  function automatic int rr_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/gray_arb_rr_pick.sv
// rtl/gray_arb_rr_pick.sv - combinational round-robin picker
// First requester at or above rr_ptr wins, wrapping modulo NUM_REQ.
module gray_arb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      winner,
  output logic               any_req
);

  int idx;

  always_comb begin
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        winner     = IW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_mem_arbiter.sv
// rtl/gray_mem_arbiter.sv - round-robin arbiter with window lock for the gray image read port
// Read returns are steered back to their issuer by an owner-tag pipeline that tracks mem_rd.
module gray_mem_arbiter
  import gray_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_ready,
  output logic                  mem_rd,
  output logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_rdata,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ-1:0]    lock,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  state_t               state, state_nx;
  logic [IW-1:0]        rr_ptr, rr_ptr_nx;
  logic [IW-1:0]        owner, owner_nx;
  logic [BW-1:0]        burst_cnt, burst_nx;
  logic [IW-1:0]        gidx;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        winner;
  logic                 any_req;
  logic                 gnt_any;

  logic [MEM_LAT:0]     tag_v;
  logic [IW-1:0]        tag_id [MEM_LAT+1];

  gray_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant   (pick_gnt),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    gnt       = '0;
    gidx      = winner;
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    owner_nx  = owner;
    burst_nx  = burst_cnt;
    if (mem_ready) begin
      case (state)
        S_ARB: begin
          if (any_req) begin
            gnt = pick_gnt;
            if (lock[winner] && MAX_BURST > 1) begin
              owner_nx = winner;
              burst_nx = BW'(1);
              state_nx = S_LOCK;
            end else begin
              rr_ptr_nx = IW'(rr_inc(int'(winner), NUM_REQ));
            end
          end
        end
        S_LOCK: begin
          gidx = owner;
          if (req[owner]) begin
            gnt[owner] = 1'b1;
            if (lock[owner] && burst_cnt < BW'(MAX_BURST - 1)) begin
              burst_nx = burst_cnt + BW'(1);
            end else begin
              rr_ptr_nx = IW'(rr_inc(int'(owner), NUM_REQ));
              burst_nx  = '0;
              state_nx  = S_ARB;
            end
          end else begin
            // Owner walked away mid-window: give the port back without a grant.
            rr_ptr_nx = IW'(rr_inc(int'(owner), NUM_REQ));
            burst_nx  = '0;
            state_nx  = S_ARB;
          end
        end
        default: state_nx = S_ARB;
      endcase
    end
  end

  assign gnt_any = |gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      owner     <= owner_nx;
      burst_cnt <= burst_nx;
      mem_rd    <= gnt_any;
      if (gnt_any) mem_addr <= addr[gidx*AW +: AW];
    end
  end

  // Tag stage k is valid in the cycle k after mem_rd; the last stage lines up with mem_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v  <= '0;
      for (int k = 0; k <= MEM_LAT; k++) tag_id[k] <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gidx;
      for (int k = 1; k <= MEM_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      rvalid <= '0;
      if (tag_v[MEM_LAT]) begin
        rvalid[tag_id[MEM_LAT]] <= 1'b1;
        rdata                   <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// tb/tb_gray_mem_arbiter.sv - scoreboard bench for gray_mem_arbiter
module tb_gray_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_ready;
  logic        mem_rd;
  logic [13:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [1:0]  req;
  logic [27:0] addr;
  logic [1:0]  lock;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [7:0]  rdata;

  gray_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .req       (req),
    .addr      (addr),
    .lock      (lock),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] oh;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   errors = 0;
  int   checks = 0;
  exp_t e;
  int   t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      lat_q.delete();
    end else begin
      if (rvalid != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", rvalid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_owner", rvalid, e.oh);
          chk("rdata", rdata, e.data);
        end
        if (lat_q.size() == 0) begin
          chk("rvalid_without_grant", rvalid, 0);
        end else begin
          t = lat_q.pop_front();
          chk("return_latency", cyc - t, 3);
        end
      end
      if (gnt != 2'b00) lat_q.push_back(cyc);
    end
  end

  task automatic beat(input logic [1:0] r, input logic [1:0] l, input logic [13:0] a0,
                      input logic [13:0] a1, input logic [1:0] eg, input bit push,
                      input string name);
    exp_t item;
    req  = r;
    lock = l;
    addr = {a1, a0};
    @(negedge clk);
    chk(name, gnt, eg);
    if (push && eg != 2'b00) begin
      item.oh   = eg;
      item.data = eg[0] ? a0[7:0] : a1[7:0];
      exp_q.push_back(item);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(2'b00, 2'b00, 14'h0, 14'h0, 2'b00, 0, "idle_gnt");
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    req       = 2'b00;
    lock      = 2'b00;
    addr      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single read
    beat(2'b01, 2'b00, 14'h0081, 14'h0000, 2'b01, 1, "t1_gnt");
    chk("t1_mem_rd", mem_rd, 1);
    chk("t1_mem_addr", mem_addr, 14'h0081);
    idle(3);

    // contention, starting from rr_ptr=0
    beat(2'b10, 2'b00, 14'h0000, 14'h0102, 2'b10, 1, "t2_pre_gnt");
    beat(2'b11, 2'b00, 14'h0010, 14'h0020, 2'b01, 1, "t2_gnt_a");
    beat(2'b11, 2'b00, 14'h0011, 14'h0020, 2'b10, 1, "t2_gnt_b");
    chk("t2_mem_rd_b2b", mem_rd, 1);
    beat(2'b11, 2'b00, 14'h0011, 14'h0021, 2'b01, 1, "t2_gnt_c");
    beat(2'b11, 2'b00, 14'h0012, 14'h0021, 2'b10, 1, "t2_gnt_d");
    chk("t2_mem_addr_d", mem_addr, 14'h0021);

    // locked 3x3 window for engine1 while engine0 waits
    beat(2'b01, 2'b00, 14'h0030, 14'h0000, 2'b01, 1, "t3_pre_gnt");
    for (int k = 0; k < 9; k++)
      beat(2'b11, (k < 8) ? 2'b10 : 2'b00, 14'h0031, 14'h0040 + 14'(k), 2'b10, 1, "t3_lock_gnt");
    beat(2'b01, 2'b00, 14'h0031, 14'h0000, 2'b01, 1, "t3_after_gnt");

    // lock held past MAX_BURST forces a rotation
    for (int k = 0; k < 9; k++)
      beat(2'b11, 2'b10, 14'h0032, 14'h0050 + 14'(k), 2'b10, 1, "t4_burst_gnt");
    beat(2'b11, 2'b10, 14'h0032, 14'h0059, 2'b01, 1, "t4_rotate_gnt");
    for (int k = 0; k < 3; k++)
      beat(2'b11, 2'b10, 14'h0033, 14'h0059 + 14'(k), 2'b10, 1, "t4_relock_gnt");
    beat(2'b01, 2'b00, 14'h0033, 14'h0000, 2'b00, 1, "t4_owner_drop_gnt");
    beat(2'b01, 2'b00, 14'h0033, 14'h0000, 2'b01, 1, "t4_release_gnt");

    // mem_ready low stalls the port
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(2'b01, 2'b00, 14'h0034, 14'h0000, 2'b00, 1, "t5_stall_gnt");
      chk("t5_stall_mem_rd", mem_rd, 0);
    end
    mem_ready = 1'b1;
    beat(2'b01, 2'b00, 14'h0034, 14'h0000, 2'b01, 1, "t5_resume_gnt");
    idle(4);

    // reset one cycle after a grant drops the in-flight read
    beat(2'b01, 2'b00, 14'h0035, 14'h0000, 2'b01, 0, "t6_gnt");
    req   = 2'b00;
    reset = 1'b1;
    #1;
    chk("t6_rst_mem_rd", mem_rd, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    chk("t6_rst_rvalid", rvalid, 0);
    chk("t6_rst_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    beat(2'b01, 2'b00, 14'h0036, 14'h0000, 2'b01, 1, "t6_post_gnt");
    idle(5);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("latency_queue_drained", lat_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
